// File: rtl/password_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : password_game_ctrl
// Brief    : Round controller for the password game. It debounces the enter
//            button, draws passwords from an LFSR, strobes the checker and
//            scores its results.
// Revision : 1.0
// ============================================================================
module password_game_ctrl #(
    parameter int         MAX_ATTEMPTS    = 3,
    parameter int         ROUNDS_TO_WIN   = 3,
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter int         RESULT_TIMEOUT  = 4,
    parameter logic [9:0] LFSR_SEED       = 10'h2A5
) (
    input  logic       clk,
    input  logic       resetBit,
    input  logic       enterBtn,
    input  logic       success,
    input  logic       changeLED,
    input  logic [9:0] numberCorrect,
    output logic       enter,
    output logic [9:0] Password,
    output logic [9:0] ledOut,
    output logic [1:0] attemptsLeft,
    output logic [1:0] numberSuccess,
    output logic       gameWon,
    output logic       lockedOut
);

    localparam int               c_DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int               c_TO_W    = $clog2(RESULT_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(RESULT_TIMEOUT - 1);
    localparam logic [1:0]       c_MAX_ATT = 2'(MAX_ATTEMPTS);
    localparam logic [1:0]       c_RW      = 2'(ROUNDS_TO_WIN);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_GEN     = 3'd1;
    localparam logic [2:0] c_WAIT_IN = 3'd2;
    localparam logic [2:0] c_CHECK   = 3'd3;
    localparam logic [2:0] c_RESULT  = 3'd4;
    localparam logic [2:0] c_WON     = 3'd5;
    localparam logic [2:0] c_LOCKED  = 3'd6;

    logic              r_sync1, r_sync2;
    logic              r_db, r_db_q, r_press;
    logic [c_DB_W-1:0] r_db_cnt;
    logic [9:0]        r_lfsr;
    logic [2:0]        r_state;
    logic [c_TO_W-1:0] r_tcnt;
    logic              r_enter, r_won, r_lock;
    logic [9:0]        r_pwd, r_led;
    logic [1:0]        r_att, r_nsucc;

    logic w_win, w_timeout, w_judge;

    // The debounced level flips only after the synchronized input has disagreed
    // with it for DEBOUNCE_CYCLES consecutive cycles; press is registered.
    always_ff @(posedge clk or posedge resetBit) begin
        if (resetBit) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_db     <= 1'b0;
            r_db_q   <= 1'b0;
            r_db_cnt <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= enterBtn;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            r_press <= r_db & ~r_db_q;
            if (r_sync2 != r_db) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_db     <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge resetBit) begin
        if (resetBit) r_lfsr <= LFSR_SEED;
        else          r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    end

    assign w_win     = success | (numberCorrect == 10'h3FF);
    assign w_timeout = ~changeLED & (r_tcnt == c_TO_LAST);
    assign w_judge   = changeLED | w_timeout;

    always_ff @(posedge clk or posedge resetBit) begin
        if (resetBit) begin
            r_state <= c_IDLE;
            r_tcnt  <= '0;
            r_enter <= 1'b0;
            r_won   <= 1'b0;
            r_lock  <= 1'b0;
            r_pwd   <= '0;
            r_led   <= '0;
            r_att   <= '0;
            r_nsucc <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (r_press) begin
                        r_state <= c_GEN;
                        r_nsucc <= '0;
                        r_led   <= '0;
                    end
                end
                c_GEN: begin
                    r_pwd   <= r_lfsr;
                    r_att   <= c_MAX_ATT;
                    r_state <= c_WAIT_IN;
                end
                c_WAIT_IN: begin
                    if (r_press) begin
                        r_state <= c_CHECK;
                        r_enter <= 1'b1;
                        r_tcnt  <= '0;
                    end
                end
                c_CHECK: begin
                    r_enter <= 1'b0;
                    r_state <= c_RESULT;
                end
                c_RESULT: begin
                    if (!w_judge) begin
                        r_tcnt <= r_tcnt + c_TO_W'(1);
                    end else begin
                        // A silent checker scores as a failed attempt with no LEDs lit.
                        r_led <= changeLED ? numberCorrect : 10'h000;
                        if (changeLED && w_win) begin
                            if (r_nsucc != c_RW) r_nsucc <= r_nsucc + 2'd1;
                            if (r_nsucc + 2'd1 == c_RW) begin
                                r_state <= c_WON;
                                r_won   <= 1'b1;
                            end else begin
                                r_state <= c_GEN;
                            end
                        end else if (r_att <= 2'd1) begin
                            r_att   <= 2'd0;
                            r_state <= c_LOCKED;
                            r_lock  <= 1'b1;
                        end else begin
                            r_att   <= r_att - 2'd1;
                            r_state <= c_WAIT_IN;
                        end
                    end
                end
                c_WON, c_LOCKED: begin
                    if (r_press) begin
                        r_state <= c_IDLE;
                        r_won   <= 1'b0;
                        r_lock  <= 1'b0;
                        r_pwd   <= '0;
                        r_led   <= '0;
                        r_att   <= '0;
                        r_nsucc <= '0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign enter         = r_enter;
    assign Password      = r_pwd;
    assign ledOut        = r_led;
    assign attemptsLeft  = r_att;
    assign numberSuccess = r_nsucc;
    assign gameWon       = r_won;
    assign lockedOut     = r_lock;

endmodule
`default_nettype wire
